// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the parametrised FIFO:
//   - clog2 : constant function giving the address width for a depth.
//   - DEF_* : default parameter values (match the older fixed 8x8 FIFO).
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_AE_LEVEL = 1;

    // Smallest r such that 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// -----------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage, DEPTH x DATA_W, one clock.
// Ports:
//   clk            : clock, rising edge
//   reset          : synchronous active-high, clears only the read register
//   we/waddr/wdata : synchronous write port
//   re/raddr       : synchronous read request / address
//   rdata          : registered read data, holds when re is low
// A read and a write to the same address in one cycle return the stored
// (old) entry, because the read samples the array before the write lands.
// -----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = clog2(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Storage array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Next read-data value: load on request, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Read-data register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= {DATA_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// -----------------------------------------------------------------------------
// fifo_param
// Parametrised synchronous FIFO, drop-in successor of the fixed 8x8 FIFO.
// Ports:
//   clk, reset (sync, active-high), clear (sync flush)
//   WEN / input_data : write request and data
//   REN / output_data: read request and registered read data
//   empty, full, almost_full, almost_empty : decoded from the count register
//   count            : occupancy 0..DEPTH
//   overflow / underflow : sticky rejected-write / rejected-read flags
// Priority per cycle: reset > clear > WEN/REN.
// -----------------------------------------------------------------------------
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    WEN,
    input  logic                    REN,
    input  logic [DATA_W-1:0]       input_data,
    output logic [DATA_W-1:0]       output_data,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);

    // Elaboration-time parameter sanity checks.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of 2 and at least 2");
    end
    if (AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_param: AF_LEVEL must not exceed DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
        $error("fifo_param: AE_LEVEL must be below DEPTH");
    end

    logic [AW-1:0] wr_ptr_d, wr_ptr_q;
    logic [AW-1:0] rd_ptr_d, rd_ptr_q;
    logic [AW:0]   count_d, count_q;
    logic          overflow_d, overflow_q;
    logic          underflow_d, underflow_q;
    logic          rd_ok_s, wr_ok_s;
    logic          ram_we_s, ram_re_s;

    // Accept decisions; a read frees the slot so a full FIFO still takes a
    // simultaneous write. clear and reset suppress all storage activity.
    always_comb begin
        rd_ok_s  = REN && (count_q != (AW+1)'(0));
        wr_ok_s  = WEN && ((count_q != CNT_FULL) || rd_ok_s);
        ram_we_s = wr_ok_s && !clear && !reset;
        ram_re_s = rd_ok_s && !clear;
    end

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {(AW+1){1'b0}};
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of 2.
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  || (WEN && !wr_ok_s);
            underflow_d = underflow_q || (REN && !rd_ok_s);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {(AW+1){1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we_s),
        .waddr (wr_ptr_q),
        .wdata (input_data),
        .re    (ram_re_s),
        .raddr (rd_ptr_q),
        .rdata (output_data)
    );

    // Status flags decoded from the registered count.
    always_comb begin
        empty        = (count_q == (AW+1)'(0));
        full         = (count_q == CNT_FULL);
        almost_full  = (count_q >= CNT_AF);
        almost_empty = (count_q <= CNT_AE);
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0, clear = 1'b0, WEN = 1'b0, REN = 1'b0;
    logic [7:0] input_data = 8'h00;
    logic [7:0] output_data;
    logic       empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;

    fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .WEN(WEN), .REN(REN),
        .input_data(input_data), .output_data(output_data),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst, clr, wen, ren;
        logic [7:0] din;
        int       cnt;
        logic [7:0] dout;
        bit       ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit r, bit c, bit w, bit rd, logic [7:0] d,
                                int cnt, logic [7:0] dout, bit ov, bit un);
        vec_t v;
        v.rst = r; v.clr = c; v.wen = w; v.ren = rd; v.din = d;
        v.cnt = cnt; v.dout = dout; v.ovf = ov; v.unf = un;
        tbl.push_back(v);
    endfunction

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input bit r, input bit c, input bit w, input bit rd,
                       input logic [7:0] d);
        reset = r; clear = c; WEN = w; REN = rd; input_data = d;
        @(posedge clk);
        #1;
        reset = 1'b0; clear = 1'b0; WEN = 1'b0; REN = 1'b0;
    endtask

    // Flags follow from the occupancy via the threshold rules (AF=6, AE=1).
    task automatic check(input string nm, input int cnt, input logic [7:0] dv,
                         input bit ov, input bit un);
        logic [17:0] exp_v, act_v;
        exp_v = {4'(cnt), dv, (cnt == 0), (cnt == DEPTH), (cnt >= 6), (cnt <= 1), ov, un};
        act_v = {count, output_data, empty, full, almost_full, almost_empty, overflow, underflow};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got {cnt,dout,e,f,af,ae,ovf,unf}=%h required %h", nm, act_v, exp_v);
        end
    endtask

    // Behavioural reference: a queue plus the last-read value and error flags.
    logic [7:0] mq[$];
    logic [7:0] m_out;
    bit         m_ovf, m_unf;

    task automatic model_step(input bit r, input bit c, input bit w, input bit rd,
                              input logic [7:0] d);
        bit do_rd, do_wr;
        if (r) begin
            mq.delete(); m_out = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else if (c) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            do_rd = rd && (mq.size() > 0);
            do_wr = w && ((mq.size() < DEPTH) || do_rd);
            if (do_rd) m_out = mq.pop_front();
            if (do_wr) mq.push_back(d);
            if (w && !do_wr) m_ovf = 1'b1;
            if (rd && !do_rd) m_unf = 1'b1;
        end
    endtask

    logic [7:0] d1[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [7:0] d3[8] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

    initial begin
        // ---- Table: fill, overflow, drain, underflow, wrap-around ----
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, d1[i], i + 1, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'hAA, 8, 8'h00, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 8'h00, 7 - i, d1[i], 1, 0);
        add(0, 0, 0, 1, 8'h00, 0, 8'hFF, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, d3[i], i + 1, 8'hFF, 1, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 8'h00, 7 - i, d3[i], 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].clr, tbl[i].wen, tbl[i].ren, tbl[i].din);
            check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].ovf, tbl[i].unf);
        end

        // ---- Simultaneous access: full and empty ----
        cyc(0, 1, 0, 0, 8'h00);
        check("clr_pre_sim", 0, 8'h80, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 8'hA0 + 8'(i));
            check($sformatf("fill_a%0d", i), i + 1, 8'h80, 0, 0);
        end
        cyc(0, 0, 1, 1, 8'h55);
        check("full_wr_rd", 8, 8'hA0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 8'h00);
            check($sformatf("drain_a%0d", i), 7 - i, (i < 7) ? 8'hA1 + 8'(i) : 8'h55, 0, 0);
        end
        cyc(0, 0, 1, 1, 8'h66);
        check("empty_wr_rd", 1, 8'h55, 0, 1);
        cyc(0, 0, 0, 1, 8'h00);
        check("read_66", 0, 8'h66, 0, 1);

        // ---- Flush with count=5 and overflow set, write in the same cycle ----
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0, 8'hB0 + 8'(i));
            check($sformatf("fill_b%0d", i), i + 1, 8'h66, 0, 1);
        end
        cyc(0, 0, 1, 0, 8'hEE);
        check("ovf_b", 8, 8'h66, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 8'h00);
            check($sformatf("rd_b%0d", i), 7 - i, 8'hB0 + 8'(i), 1, 1);
        end
        cyc(0, 1, 1, 0, 8'hCC);
        check("flush", 0, 8'hB2, 0, 0);
        cyc(0, 0, 0, 1, 8'h00);
        check("flush_no_write", 0, 8'hB2, 0, 1);

        // ---- Reset mid-burst ----
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'hC1 + 8'(i));
            check($sformatf("fill_c%0d", i), i + 1, 8'hB2, 0, 1);
        end
        cyc(1, 0, 1, 0, 8'hDD);
        check("mid_reset", 0, 8'h00, 0, 0);
        cyc(0, 0, 1, 0, 8'h5A);
        check("wr_5a", 1, 8'h00, 0, 0);
        cyc(0, 0, 0, 1, 8'h00);
        check("rd_5a", 0, 8'h5A, 0, 0);

        // ---- Randomised traffic against the reference model ----
        cyc(1, 0, 0, 0, 8'h00);
        model_step(1, 0, 0, 0, 8'h00);
        begin
            int wprob;
            bit r, c, w, rd;
            logic [7:0] d;
            wprob = 50;
            for (int n = 0; n < 3000; n++) begin
                if ((n % 64) == 0) wprob = int'($urandom_range(10, 90));
                r  = ($urandom_range(0, 299) == 0);
                c  = ($urandom_range(0, 149) == 0);
                w  = (int'($urandom_range(0, 99)) < wprob);
                rd = (int'($urandom_range(0, 99)) >= wprob);
                d  = 8'($urandom);
                cyc(r, c, w, rd, d);
                model_step(r, c, w, rd, d);
                check($sformatf("rand%0d", n), mq.size(), m_out, m_ovf, m_unf);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
